// File: rtl/inst_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: next-PC select codes
// and the address alignment helper.
// Optional feature macro: NPC_JR_EN (enables decoding of NPC_OP_JR).
package inst_fetch_unit_pkg;

    localparam int NPC_OP_LENGTH = 2;

    typedef enum logic [NPC_OP_LENGTH-1:0] {
        NPC_OP_NEXT   = 2'b00,
        NPC_OP_OFFSET = 2'b01,
        NPC_OP_JUMP   = 2'b10,
        NPC_OP_JR     = 2'b11
    } npc_op_e;

    localparam logic [31:0] PC_STEP = 32'd4;

    // True when the address sits on a 32-bit word boundary.
    function automatic logic addr_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/inst_fetch_unit_npc_calc.sv
// Combinational next-PC generator: sequential, PC-relative branch, region
// jump and (with NPC_JR_EN) register-indirect jump.
// Optional feature macro: NPC_JR_EN.
module npc_calc
    import inst_fetch_unit_pkg::*;
(
    input  logic [31:0]              pc,
    input  logic [31:0]              inst,
    input  logic [NPC_OP_LENGTH-1:0] npc_op,
    input  logic [31:0]              rs_data,
    output logic [31:0]              npc,
    output logic [31:0]              pc_plus4
);

    logic [31:0] br_off_s;
    logic        unused_bits_s;

    assign pc_plus4 = pc + PC_STEP;
    assign br_off_s = {{14{inst[15]}}, inst[15:0], 2'b00};

`ifdef NPC_JR_EN
    assign unused_bits_s = ^inst[31:26];
`else
    // rs_data only feeds the register-indirect jump, absent in this build.
    assign unused_bits_s = ^{inst[31:26], rs_data};
`endif

    // Select the next PC; unknown selects fall back to the sequential path.
    always_comb begin
        npc = pc_plus4;
        case (npc_op)
            NPC_OP_NEXT:   npc = pc_plus4;
            NPC_OP_OFFSET: npc = pc_plus4 + br_off_s;
            NPC_OP_JUMP:   npc = {pc_plus4[31:28], inst[25:0], 2'b00};
`ifdef NPC_JR_EN
            NPC_OP_JR:     npc = rs_data;
`endif
            default:       npc = pc_plus4;
        endcase
    end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: holds the PC, fetches one word from imem per
// instruction, presents it for decode and advances the PC when the datapath
// releases it. Misaligned targets and imem timeouts halt the unit until reset.
// Optional feature macro: NPC_JR_EN (register-indirect jump via rs_data).
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          IMEM_TMO = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    output logic                     imem_req,
    output logic [31:0]              imem_addr,
    input  logic [31:0]              imem_rdata,
    input  logic                     imem_ready,
    input  logic [NPC_OP_LENGTH-1:0] npc_op,
    input  logic                     ex_stall,
    input  logic [31:0]              rs_data,
    output logic [31:0]              inst,
    output logic                     inst_valid,
    output logic [5:0]               opcode,
    output logic [4:0]               sa,
    output logic [5:0]               func,
    output logic [31:0]              pc,
    output logic [31:0]              pc_plus4,
    output logic                     fetch_err
);

    localparam int TMO_W = $clog2(IMEM_TMO + 1);
    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(IMEM_TMO);

    typedef enum logic [1:0] {
        S_FETCH = 2'b00,
        S_EXEC  = 2'b01,
        S_HALT  = 2'b10
    } state_e;

    state_e           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      inst_q, inst_d;
    logic             inst_valid_q, inst_valid_d;
    logic             imem_req_q, imem_req_d;
    logic             fetch_err_q, fetch_err_d;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [TMO_W-1:0] tmo_inc_s;
    logic [31:0]      npc_s;

    npc_calc u_npc_calc (
        .pc       (pc_q),
        .inst     (inst_q),
        .npc_op   (npc_op),
        .rs_data  (rs_data),
        .npc      (npc_s),
        .pc_plus4 (pc_plus4)
    );

    assign tmo_inc_s = tmo_cnt_q + TMO_W'(1);

    // Fetch/execute sequencing; a request is only live once imem_req is
    // actually driven, so ready seen in the first cycle after reset is ignored.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_d       = inst_q;
        inst_valid_d = inst_valid_q;
        imem_req_d   = imem_req_q;
        fetch_err_d  = fetch_err_q;
        tmo_cnt_d    = tmo_cnt_q;
        case (state_q)
            S_FETCH: begin
                if (!imem_req_q) begin
                    imem_req_d = 1'b1;
                end else if (imem_ready) begin
                    inst_d       = imem_rdata;
                    inst_valid_d = 1'b1;
                    imem_req_d   = 1'b0;
                    tmo_cnt_d    = '0;
                    state_d      = S_EXEC;
                end else if (tmo_inc_s == TMO_LIMIT) begin
                    fetch_err_d = 1'b1;
                    imem_req_d  = 1'b0;
                    tmo_cnt_d   = tmo_inc_s;
                    state_d     = S_HALT;
                end else begin
                    tmo_cnt_d = tmo_inc_s;
                end
            end
            S_EXEC: begin
                if (ex_stall) begin
                    state_d = S_EXEC;
                end else if (!addr_aligned(npc_s)) begin
                    fetch_err_d  = 1'b1;
                    inst_valid_d = 1'b0;
                    state_d      = S_HALT;
                end else begin
                    pc_d         = npc_s;
                    inst_valid_d = 1'b0;
                    imem_req_d   = 1'b1;
                    state_d      = S_FETCH;
                end
            end
            S_HALT: begin
                imem_req_d   = 1'b0;
                inst_valid_d = 1'b0;
                state_d      = S_HALT;
            end
            default: begin
                imem_req_d   = 1'b0;
                inst_valid_d = 1'b0;
                fetch_err_d  = 1'b1;
                state_d      = S_HALT;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_FETCH;
            pc_q         <= RESET_PC;
            inst_q       <= 32'd0;
            inst_valid_q <= 1'b0;
            imem_req_q   <= 1'b0;
            fetch_err_q  <= 1'b0;
            tmo_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            inst_valid_q <= inst_valid_d;
            imem_req_q   <= imem_req_d;
            fetch_err_q  <= fetch_err_d;
            tmo_cnt_q    <= tmo_cnt_d;
        end
    end

    assign imem_req   = imem_req_q;
    assign imem_addr  = pc_q;
    assign inst       = inst_q;
    assign inst_valid = inst_valid_q;
    assign opcode     = inst_q[31:26];
    assign sa         = inst_q[10:6];
    assign func       = inst_q[5:0];
    assign pc         = pc_q;
    assign fetch_err  = fetch_err_q;

endmodule
